// File: rtl/conv3_requant_pack_if.sv
// Handshake and configuration bundle between the conv3 output stage and its neighbours.
// The master drives elements and config; the slave (the stage) drives the SRAM word side.
interface conv3_requant_pack_if #(
  parameter int ACC_W  = 25,
  parameter int ADDR_W = 16
);
  logic                     start;
  logic [ADDR_W-1:0]        cfg_base;
  logic [4:0]               cfg_shift;
  logic                     cfg_relu;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  acc_in;
  logic signed [ACC_W-1:0]  bias_in;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic [3:0]               out_be;
  logic [ADDR_W-1:0]        out_addr;
  logic                     busy;
  logic                     done;

  modport master (
    output start, cfg_base, cfg_shift, cfg_relu,
    output in_valid, acc_in, bias_in, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_be, out_addr, busy, done
  );

  modport slave (
    input  start, cfg_base, cfg_shift, cfg_relu,
    input  in_valid, acc_in, bias_in, in_last, out_ready,
    output in_ready, out_valid, out_data, out_be, out_addr, busy, done
  );
endinterface

// File: rtl/conv3_requant_pack.sv
// conv3 output stage: bias add, round-half-up shift, optional ReLU, int8 saturation,
// and packing of four lanes per 32-bit word toward the feature-map SRAM.
module conv3_requant_pack #(
  parameter int ACC_W  = 25,
  parameter int ADDR_W = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  conv3_requant_pack_if.slave   bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  localparam logic signed [ACC_W+1:0] RND_ONE = {{(ACC_W+1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W+1:0] SAT_HI  = {{(ACC_W-5){1'b0}}, 7'h7F};
  localparam logic signed [ACC_W+1:0] SAT_LO  = {{(ACC_W-5){1'b1}}, 7'h00};
  localparam logic [ADDR_W-1:0]       ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // The sum is widened by one more bit so the rounding constant can never overflow it.
  function automatic logic [7:0] requant(input logic signed [ACC_W:0] sum,
                                         input logic [4:0] sh, input logic relu);
    logic signed [ACC_W+1:0] v_ext;
    logic signed [ACC_W+1:0] v_rnd;
    logic signed [ACC_W+1:0] v_r;
    v_ext = {sum[ACC_W], sum};
    if (sh != 5'd0) v_rnd = RND_ONE << (sh - 5'd1);
    else            v_rnd = '0;
    v_r = (v_ext + v_rnd) >>> sh;
    if (relu && (v_r < 0)) v_r = '0;
    else                   v_r = v_r;
    if (v_r > SAT_HI)      return 8'h7F;
    else if (v_r < SAT_LO) return 8'h80;
    else                   return v_r[7:0];
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_busy;
  logic                    r_done;
  logic [4:0]              r_shift;
  logic                    r_relu;
  logic                    r_s1_valid;
  logic signed [ACC_W:0]   r_s1_sum;
  logic                    r_s1_last;
  logic [1:0]              r_lane_cnt;
  logic [31:0]             r_word;
  logic [3:0]              r_be;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [31:0]             r_out_data;
  logic [3:0]              r_out_be;
  logic [ADDR_W-1:0]       r_out_addr;

  logic                    w_adv;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_out_hs;
  logic                    w_last_hs;
  logic                    w_start;
  logic                    w_emit;
  logic [7:0]              w_byte;
  logic [31:0]             w_word;
  logic [3:0]              w_be;

  assign w_adv      = !(r_out_valid && !bus.out_ready);
  assign w_in_ready = (r_state == ST_RUN) && w_adv;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && bus.out_ready;
  assign w_last_hs  = (r_state == ST_DRAIN) && w_out_hs && r_out_last;
  assign w_start    = (r_state == ST_IDLE) && bus.start;
  assign w_emit     = r_s1_valid && ((r_lane_cnt == 2'd3) || r_s1_last);
  assign w_byte     = requant(r_s1_sum, r_shift, r_relu);

  // Next-state decode of the run controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_RUN;   else w_state_nxt = ST_IDLE;
      ST_RUN:   if (w_accept && bus.in_last) w_state_nxt = ST_DRAIN; else w_state_nxt = ST_RUN;
      ST_DRAIN: if (w_last_hs) w_state_nxt = ST_IDLE;  else w_state_nxt = ST_DRAIN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Merge the freshly requantised byte into the lane selected by the lane counter.
  always_comb begin
    w_word = r_word;
    w_be   = r_be;
    case (r_lane_cnt)
      2'd0:    begin w_word[7:0]   = w_byte; w_be[0] = 1'b1; end
      2'd1:    begin w_word[15:8]  = w_byte; w_be[1] = 1'b1; end
      2'd2:    begin w_word[23:16] = w_byte; w_be[2] = 1'b1; end
      2'd3:    begin w_word[31:24] = w_byte; w_be[3] = 1'b1; end
      default: begin w_word = r_word; w_be = r_be; end
    endcase
  end

  // Controller state plus the busy/done status flags.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_last_hs;
    end
  end

  // Tile configuration captured on an accepted start.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shift <= 5'd0;
      r_relu  <= 1'b0;
    end else if (w_start) begin
      r_shift <= bus.cfg_shift;
      r_relu  <= bus.cfg_relu;
    end
  end

  // Datapath: S1 sum, S2 requant/pack, and the output word register; all stall on !adv.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_last   <= 1'b0;
      r_lane_cnt  <= 2'd0;
      r_word      <= 32'h0000_0000;
      r_be        <= 4'h0;
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= 32'h0000_0000;
      r_out_be    <= 4'h0;
      r_out_addr  <= '0;
    end else if (w_start) begin
      r_s1_valid <= 1'b0;
      r_lane_cnt <= 2'd0;
      r_word     <= 32'h0000_0000;
      r_be       <= 4'h0;
      r_addr     <= bus.cfg_base;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      r_s1_sum   <= {bus.acc_in[ACC_W-1], bus.acc_in} + {bus.bias_in[ACC_W-1], bus.bias_in};
      r_s1_last  <= bus.in_last;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_last  <= r_s1_last;
        r_out_data  <= w_word;
        r_out_be    <= w_be;
        r_out_addr  <= r_addr;
        r_addr      <= r_addr + ADDR_ONE;
        r_lane_cnt  <= 2'd0;
        r_word      <= 32'h0000_0000;
        r_be        <= 4'h0;
      end else begin
        // adv with a word pending implies it was just taken, so the slot frees up.
        r_out_valid <= 1'b0;
        if (r_s1_valid) begin
          r_lane_cnt <= r_lane_cnt + 2'd1;
          r_word     <= w_word;
          r_be       <= w_be;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_be    = r_out_be;
  assign bus.out_addr  = r_out_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_conv3_requant_pack.sv
// Directed bench for conv3_requant_pack: hand-computed packed words, addresses, byte
// enables, backpressure, address wrap and asynchronous reset mid-run.
module tb_conv3_requant_pack;
  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  conv3_requant_pack_if bus ();
  conv3_requant_pack u_dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  logic [51:0] words[$];
  int done_cnt = 0;
  int done_at  = 0;

  // Log every word handshake ({addr, be, data}) and every done pulse.
  always @(negedge CLK) begin
    if (bus.out_valid && bus.out_ready) words.push_back({bus.out_addr, bus.out_be, bus.out_data});
    if (bus.done) begin
      done_cnt = done_cnt + 1;
      done_at  = words.size();
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_log();
    words.delete();
    done_cnt = 0;
    done_at  = 0;
  endtask

  task automatic start_run(input logic [15:0] base, input logic [4:0] sh, input logic relu);
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.cfg_base = base; bus.cfg_shift = sh; bus.cfg_relu = relu;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic signed [24:0] acc, input logic signed [24:0] bias, input logic last);
    bus.in_valid = 1'b1; bus.acc_in = acc; bus.bias_in = bias; bus.in_last = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (bus.in_ready) break;
    end
    chk("send_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (done_cnt > 0) break;
    end
    repeat (4) @(negedge CLK);
    chk(tag, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    RSTn = 1'b0;
    bus.start = 1'b0; bus.cfg_base = 16'h0000; bus.cfg_shift = 5'd0; bus.cfg_relu = 1'b0;
    bus.in_valid = 1'b0; bus.acc_in = 25'sd0; bus.bias_in = 25'sd0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, bus.busy},      64'd0);
    chk("rst_done",      {63'd0, bus.done},      64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    chk("rst_out_bus",   {12'd0, bus.out_addr, bus.out_be, bus.out_data}, 64'd0);
    RSTn = 1'b1;

    // T1: saturation, negative rounding, last on 4th lane
    clear_log();
    start_run(16'h0100, 5'd8, 1'b0);
    chk("t1_busy", {63'd0, bus.busy}, 64'd1);
    send(25'sd256, 25'sd0, 1'b0);
    send(25'sd512, 25'sd0, 1'b0);
    send(-25'sd256, 25'sd0, 1'b0);
    send(25'sd40000, 25'sd0, 1'b1);
    wait_done("t1_done_once");
    chk("t1_nwords", 64'(words.size()), 64'd1);
    chk("t1_word", 64'(words[0]), {12'd0, 16'h0100, 4'hF, 32'h7FFF0201});
    chk("t1_idle", {63'd0, bus.busy}, 64'd0);

    // T2: round-half-up with arithmetic shift
    clear_log();
    start_run(16'h0200, 5'd4, 1'b0);
    send(25'sd8, 25'sd0, 1'b0);
    send(25'sd7, 25'sd0, 1'b0);
    send(-25'sd8, 25'sd0, 1'b0);
    send(-25'sd9, 25'sd0, 1'b1);
    wait_done("t2_done_once");
    chk("t2_word", 64'(words[0]), {12'd0, 16'h0200, 4'hF, 32'hFF000001});

    // T3: relu, bias, shift 0
    clear_log();
    start_run(16'h0300, 5'd0, 1'b1);
    send(-25'sd1000, 25'sd0, 1'b0);
    send(25'sd50, 25'sd10, 1'b0);
    send(25'sd50000, 25'sd0, 1'b0);
    send(-25'sd1, 25'sd0, 1'b1);
    wait_done("t3_done_once");
    chk("t3_word", 64'(words[0]), {12'd0, 16'h0300, 4'hF, 32'h007F3C00});

    // T4: six elements, partial second word, address wraps past 0xFFFF
    clear_log();
    start_run(16'hFFFF, 5'd0, 1'b0);
    for (int i = 1; i <= 6; i++) send(25'(i), 25'sd0, i == 6);
    wait_done("t4_done_once");
    chk("t4_nwords", 64'(words.size()), 64'd2);
    chk("t4_word0", 64'(words[0]), {12'd0, 16'hFFFF, 4'hF, 32'h04030201});
    chk("t4_word1", 64'(words[1]), {12'd0, 16'h0000, 4'h3, 32'h00000605});
    chk("t4_done_after_2nd", 64'(done_at), 64'd2);

    // T5: 12-element stream with a 10-cycle stall after the first word
    clear_log();
    start_run(16'h0400, 5'd0, 1'b0);
    fork
      begin
        for (int i = 0; i < 12; i++) send(25'(16 + i), 25'sd0, i == 11);
      end
      begin
        for (int n = 0; n < 200; n++) begin
          @(posedge CLK); #1;
          if (bus.out_valid) break;
        end
        bus.out_ready = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t5_stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("t5_stall_hold", {32'd0, bus.out_data}, 64'h13121110);
        @(posedge CLK); repeat (4) @(posedge CLK); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done("t5_done_once");
    chk("t5_nwords", 64'(words.size()), 64'd3);
    chk("t5_word0", 64'(words[0]), {12'd0, 16'h0400, 4'hF, 32'h13121110});
    chk("t5_word1", 64'(words[1]), {12'd0, 16'h0401, 4'hF, 32'h17161514});
    chk("t5_word2", 64'(words[2]), {12'd0, 16'h0402, 4'hF, 32'h1B1A1918});

    // T6: asynchronous reset with a word pending in RUN
    clear_log();
    start_run(16'h0600, 5'd0, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(25'(i + 1), 25'sd0, 1'b0);
    @(posedge CLK); #1;
    chk("t6_pending", {63'd0, bus.out_valid}, 64'd1);
    @(posedge CLK); #3;
    RSTn = 1'b0;
    #1;
    chk("t6_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t6_rst_busy",      {63'd0, bus.busy},      64'd0);
    chk("t6_rst_done",      {63'd0, bus.done},      64'd0);
    #10;
    RSTn = 1'b1;
    bus.out_ready = 1'b1;
    clear_log();
    start_run(16'h0500, 5'd0, 1'b0);
    send(25'sd33, 25'sd0, 1'b0);
    send(25'sd34, 25'sd0, 1'b0);
    send(25'sd35, 25'sd0, 1'b0);
    send(25'sd36, 25'sd0, 1'b1);
    wait_done("t6_done_once");
    chk("t6_nwords", 64'(words.size()), 64'd1);
    chk("t6_word", 64'(words[0]), {12'd0, 16'h0500, 4'hF, 32'h24232221});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
